coherent_dcache: RTL and testbench

//  Per-CPU data cache: direct-mapped, 8 sets, 2-word blocks, MSI coherence. It is the cache-side end of the

---
 rtl/coherent_dcache_pkg.sv | 33 +++
 rtl/coherent_dcache.sv | 238 +++++++++++++++++++++++
 tb/tb_coherent_dcache.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/coherent_dcache_pkg.sv
// Shared cache types: MSI line state, address field split and frame layout.
package coherent_dcache_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;

  typedef struct packed {
    msi_t            st;
    logic [25:0]     tag;
    word_t [1:0]     data;
  } dframe_t;

  localparam int unsigned IDX_W = 3;

  // Rebuild a bus word address from a frame's tag, set index and block offset.
  function automatic word_t word_addr(input logic [25:0] tag, input logic [IDX_W-1:0] idx,
                                      input logic blk);
    return {tag, idx, blk, 2'b00};
  endfunction

endpackage

// File: rtl/coherent_dcache.sv
// Direct-mapped, 2-word-block MSI data cache; fills and write-backs over the coherent bus,
// answers snoops and supplies dirty data on a snoop hit in M.
module coherent_dcache
  import coherent_dcache_pkg::*;
#(
  parameter int CPUID = 0,
  parameter int SETS  = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB1   = 3'd1,
    ST_WB2   = 3'd2,
    ST_LOAD1 = 3'd3,
    ST_LOAD2 = 3'd4,
    ST_SNP   = 3'd5,
    ST_SWB1  = 3'd6,
    ST_SWB2  = 3'd7
  } state_t;

  localparam int UNUSED_CPUID = CPUID;

  state_t            state_r, next_state_s;
  dframe_t           frames_r [SETS];
  dcachef_t          req_s, snp_s;
  dframe_t           req_frame_s, snp_frame_s, vic_frame_s;
  logic              req_hit_s, req_ok_s, req_pend_s, dhit_s;
  logic              snp_busy_s, snp_hit_s, snp_m_s;
  logic [25:0]       req_tag_r, req_tag_nx_s, snp_tag_r, snp_tag_nx_s;
  logic [IDX_W-1:0]  req_idx_r, req_idx_nx_s, snp_idx_r, snp_idx_nx_s;
  logic              req_upg_r, req_upg_nx_s;
  logic              dren_nx_s, dwen_nx_s, cctrans_nx_s, ccwrite_nx_s;
  word_t             daddr_nx_s, dstore_nx_s;
  logic              unused_s;

  assign req_s    = dmemaddr;
  assign snp_s    = ccsnoopaddr;
  assign unused_s = ^{req_s.bytoff, snp_s.bytoff, snp_s.blkoff};

  // Request and snoop lookups; transfer addresses are frozen once a transaction leaves IDLE.
  always_comb begin
    req_frame_s  = frames_r[req_s.idx];
    req_hit_s    = (req_frame_s.st != MSI_I) && (req_frame_s.tag == req_s.tag);
    req_ok_s     = req_hit_s && (dmemREN || (dmemWEN && (req_frame_s.st == MSI_M)));
    req_pend_s   = dmemREN || dmemWEN;
    dhit_s       = (state_r == ST_IDLE) && !ccwait && req_ok_s;
    req_tag_nx_s = (state_r == ST_IDLE) ? req_s.tag : req_tag_r;
    req_idx_nx_s = (state_r == ST_IDLE) ? req_s.idx : req_idx_r;
    req_upg_nx_s = (state_r == ST_IDLE) ? dmemWEN : req_upg_r;
    snp_busy_s   = (state_r == ST_SNP) || (state_r == ST_SWB1) || (state_r == ST_SWB2);
    snp_tag_nx_s = snp_busy_s ? snp_tag_r : snp_s.tag;
    snp_idx_nx_s = snp_busy_s ? snp_idx_r : snp_s.idx;
    snp_frame_s  = frames_r[snp_idx_nx_s];
    snp_hit_s    = (snp_frame_s.st != MSI_I) && (snp_frame_s.tag == snp_tag_nx_s);
    snp_m_s      = snp_hit_s && (snp_frame_s.st == MSI_M);
    vic_frame_s  = frames_r[req_idx_nx_s];
  end

  // Datapath-facing hit path stays combinational so a hit costs no extra cycle.
  always_comb begin
    dhit = dhit_s;
    if (dhit_s) begin
      dmemload = req_frame_s.data[req_s.blkoff];
    end else begin
      dmemload = 32'h0000_0000;
    end
  end

  // Next-state selection; snoops win only before any word of a transfer is accepted.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ccwait) begin
          next_state_s = ST_SNP;
        end else if (req_pend_s && !req_ok_s) begin
          next_state_s = (req_frame_s.st == MSI_M) ? ST_WB1 : ST_LOAD1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WB1: begin
        if (ccwait) begin
          next_state_s = ST_SNP;
        end else if (!dwait) begin
          next_state_s = ST_WB2;
        end else begin
          next_state_s = ST_WB1;
        end
      end
      ST_WB2:   next_state_s = dwait ? ST_WB2 : ST_LOAD1;
      ST_LOAD1: begin
        if (ccwait) begin
          next_state_s = ST_SNP;
        end else if (!dwait) begin
          next_state_s = ST_LOAD2;
        end else begin
          next_state_s = ST_LOAD1;
        end
      end
      ST_LOAD2: next_state_s = dwait ? ST_LOAD2 : ST_IDLE;
      ST_SNP: begin
        if (snp_m_s) begin
          next_state_s = ST_SWB1;
        end else if (!ccwait) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_SNP;
        end
      end
      ST_SWB1:  next_state_s = dwait ? ST_SWB1 : ST_SWB2;
      ST_SWB2:  next_state_s = dwait ? ST_SWB2 : ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Bus outputs for the state being entered, so they are registered yet Moore per state.
  always_comb begin
    dren_nx_s    = 1'b0;
    dwen_nx_s    = 1'b0;
    cctrans_nx_s = 1'b0;
    ccwrite_nx_s = 1'b0;
    daddr_nx_s   = 32'h0000_0000;
    dstore_nx_s  = 32'h0000_0000;
    case (next_state_s)
      ST_WB1, ST_WB2: begin
        dwen_nx_s   = 1'b1;
        daddr_nx_s  = word_addr(vic_frame_s.tag, req_idx_nx_s, next_state_s == ST_WB2);
        dstore_nx_s = vic_frame_s.data[next_state_s == ST_WB2];
      end
      ST_LOAD1, ST_LOAD2: begin
        dren_nx_s    = 1'b1;
        cctrans_nx_s = 1'b1;
        ccwrite_nx_s = req_upg_nx_s;
        daddr_nx_s   = word_addr(req_tag_nx_s, req_idx_nx_s, next_state_s == ST_LOAD2);
      end
      ST_SNP:  ccwrite_nx_s = snp_m_s;
      ST_SWB1, ST_SWB2: begin
        ccwrite_nx_s = 1'b1;
        dstore_nx_s  = snp_frame_s.data[next_state_s == ST_SWB2];
      end
      default: ccwrite_nx_s = 1'b0;
    endcase
  end

  // Controller state, latched transaction fields, output registers and frame array.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= ST_IDLE;
      req_tag_r <= 26'd0;
      req_idx_r <= '0;
      req_upg_r <= 1'b0;
      snp_tag_r <= 26'd0;
      snp_idx_r <= '0;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      cctrans   <= 1'b0;
      ccwrite   <= 1'b0;
      daddr     <= 32'h0000_0000;
      dstore    <= 32'h0000_0000;
      for (int i = 0; i < SETS; i++) begin
        frames_r[i] <= '0;
      end
    end else begin
      state_r   <= next_state_s;
      req_tag_r <= req_tag_nx_s;
      req_idx_r <= req_idx_nx_s;
      req_upg_r <= req_upg_nx_s;
      snp_tag_r <= snp_tag_nx_s;
      snp_idx_r <= snp_idx_nx_s;
      dREN      <= dren_nx_s;
      dWEN      <= dwen_nx_s;
      cctrans   <= cctrans_nx_s;
      ccwrite   <= ccwrite_nx_s;
      daddr     <= daddr_nx_s;
      dstore    <= dstore_nx_s;
      case (state_r)
        ST_IDLE: begin
          if (dhit_s && dmemWEN) begin
            frames_r[req_s.idx].data[req_s.blkoff] <= dmemstore;
          end
        end
        ST_WB2: begin
          if (!dwait) begin
            frames_r[req_idx_r].st <= MSI_I;
          end
        end
        ST_LOAD1: begin
          // The frame is invalid while half-filled so a reset or snoop never sees mixed data.
          if (!ccwait && !dwait) begin
            frames_r[req_idx_r].st      <= MSI_I;
            frames_r[req_idx_r].data[0] <= dload;
          end
        end
        ST_LOAD2: begin
          if (!dwait) begin
            frames_r[req_idx_r].data[1] <= dload;
            frames_r[req_idx_r].tag     <= req_tag_r;
            frames_r[req_idx_r].st      <= req_upg_r ? MSI_M : MSI_S;
          end
        end
        ST_SNP: begin
          if (!snp_m_s && snp_hit_s && ccinv) begin
            frames_r[snp_idx_r].st <= MSI_I;
          end
        end
        ST_SWB2: begin
          if (!dwait) begin
            frames_r[snp_idx_r].st <= ccinv ? MSI_I : MSI_S;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_dcache.sv
// Directed cycle-by-cycle vectors for coherent_dcache: fills, upgrade, write-back, snoops, reset.
module tb_coherent_dcache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, dhit, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload, ccsnoopaddr;

  always #5 CLK = ~CLK;

  coherent_dcache #(.CPUID(0), .SETS(8)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait), .cctrans(cctrans),
    .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, store, ld;
    logic        dw, ccw, cci;
    logic [31:0] snp;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_dren, e_dwen;
    logic [31:0] e_daddr, e_dstore;
    logic        e_cct, e_ccwr;
  } tv_t;

  tv_t tv[$];
  int  applied = 0;
  int  miscompares = 0;

  function automatic tv_t v(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] store, input logic [31:0] ld, input logic dw,
                            input logic ccw, input logic cci, input logic [31:0] snp,
                            input logic e_hit, input logic [31:0] e_load, input logic e_dren,
                            input logic e_dwen, input logic [31:0] e_daddr,
                            input logic [31:0] e_dstore, input logic e_cct, input logic e_ccwr);
    tv_t t;
    t.ren = ren; t.wen = wen; t.addr = addr; t.store = store; t.ld = ld; t.dw = dw;
    t.ccw = ccw; t.cci = cci; t.snp = snp; t.e_hit = e_hit; t.e_load = e_load;
    t.e_dren = e_dren; t.e_dwen = e_dwen; t.e_daddr = e_daddr; t.e_dstore = e_dstore;
    t.e_cct = e_cct; t.e_ccwr = e_ccwr;
    return t;
  endfunction

  task automatic drive(input tv_t t);
    dmemREN = t.ren; dmemWEN = t.wen; dmemaddr = t.addr; dmemstore = t.store;
    dload = t.ld; dwait = t.dw; ccwait = t.ccw; ccinv = t.cci; ccsnoopaddr = t.snp;
  endtask

  task automatic check(input tv_t t, input string name);
    applied++;
    if ({dhit, dmemload, dREN, dWEN, daddr, dstore, cctrans, ccwrite} !==
        {t.e_hit, t.e_load, t.e_dren, t.e_dwen, t.e_daddr, t.e_dstore, t.e_cct, t.e_ccwr}) begin
      miscompares++;
      $display("FAIL %s: got hit=%0b load=%h dREN=%0b dWEN=%0b daddr=%h dstore=%h cctrans=%0b ccwrite=%0b; want hit=%0b load=%h dREN=%0b dWEN=%0b daddr=%h dstore=%h cctrans=%0b ccwrite=%0b",
               name, dhit, dmemload, dREN, dWEN, daddr, dstore, cctrans, ccwrite,
               t.e_hit, t.e_load, t.e_dren, t.e_dwen, t.e_daddr, t.e_dstore, t.e_cct, t.e_ccwr);
    end
  endtask

  task automatic apply(input tv_t t, input string name);
    drive(t);
    #1;
    check(t, name);
    @(negedge CLK);
  endtask

  initial begin
    // Cold load of 0x40: no write-back, two-word fill as S, then hits on both words.
    tv.push_back(v(1,0,32'h40,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 0,0,1,0,32'h40,0,1,0));
    tv.push_back(v(1,0,32'h40,0,32'hAAAA0000,0,0,0,0, 0,0,1,0,32'h40,0,1,0));
    tv.push_back(v(1,0,32'h40,0,32'hAAAA0001,0,0,0,0, 0,0,1,0,32'h44,0,1,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 1,32'hAAAA0000,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h44,0,0,1,0,0,0, 1,32'hAAAA0001,0,0,0,0,0,0));
    // Store to a block held in S: upgrade fill with ccwrite, then store hit.
    tv.push_back(v(0,1,32'h44,32'h55551111,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(0,1,32'h44,32'h55551111,32'hBBBB0000,0,0,0,0, 0,0,1,0,32'h40,0,1,1));
    tv.push_back(v(0,1,32'h44,32'h55551111,32'hBBBB0001,0,0,0,0, 0,0,1,0,32'h44,0,1,1));
    tv.push_back(v(0,1,32'h44,32'h55551111,0,1,0,0,0, 1,32'hBBBB0001,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h44,0,0,1,0,0,0, 1,32'h55551111,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 1,32'hBBBB0000,0,0,0,0,0,0));
    // Conflict load 0x240 evicts the M block: write-back 0x40/0x44, then fill.
    tv.push_back(v(1,0,32'h240,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h240,0,0,1,0,0,0, 0,0,0,1,32'h40,32'hBBBB0000,0,0));
    tv.push_back(v(1,0,32'h240,0,0,0,0,0,0, 0,0,0,1,32'h40,32'hBBBB0000,0,0));
    tv.push_back(v(1,0,32'h240,0,0,0,0,0,0, 0,0,0,1,32'h44,32'h55551111,0,0));
    tv.push_back(v(1,0,32'h240,0,32'hCCCC0000,0,0,0,0, 0,0,1,0,32'h240,0,1,0));
    tv.push_back(v(1,0,32'h240,0,32'hCCCC0001,0,0,0,0, 0,0,1,0,32'h244,0,1,0));
    tv.push_back(v(1,0,32'h244,0,0,1,0,0,0, 1,32'hCCCC0001,0,0,0,0,0,0));
    // Store 0x44 over an S victim: no write-back, fill as M, store commits.
    tv.push_back(v(0,1,32'h44,32'h77770044,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(0,1,32'h44,32'h77770044,32'hDDDD0000,0,0,0,0, 0,0,1,0,32'h40,0,1,1));
    tv.push_back(v(0,1,32'h44,32'h77770044,32'hDDDD0001,0,0,0,0, 0,0,1,0,32'h44,0,1,1));
    tv.push_back(v(0,1,32'h44,32'h77770044,0,1,0,0,0, 1,32'hDDDD0001,0,0,0,0,0,0));
    // Snoop 0x44 hitting M without invalidate: supply both words, frame drops to S.
    tv.push_back(v(0,0,0,0,0,1,1,0,32'h44, 0,0,0,0,0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,1,0,32'h44, 0,0,0,0,0,0,0,1));
    tv.push_back(v(0,0,0,0,0,1,1,0,32'h44, 0,0,0,0,0,32'hDDDD0000,0,1));
    tv.push_back(v(0,0,0,0,0,0,1,0,32'h44, 0,0,0,0,0,32'hDDDD0000,0,1));
    tv.push_back(v(0,0,0,0,0,0,1,0,32'h44, 0,0,0,0,0,32'h77770044,0,1));
    tv.push_back(v(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h44,0,0,1,0,0,0, 1,32'h77770044,0,0,0,0,0,0));
    // Snoop 0x40 in S with invalidate: no supply, frame I, next load misses.
    tv.push_back(v(0,0,0,0,0,1,1,1,32'h40, 0,0,0,0,0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,1,1,32'h40, 0,0,0,0,0,0,0,0));
    tv.push_back(v(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    // Snoop arriving in LOAD1 before any word: SNP serviced, then the fill restarts.
    tv.push_back(v(1,0,32'h40,0,0,1,1,1,32'h300, 0,0,1,0,32'h40,0,1,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h40,0,0,1,0,0,0, 0,0,0,0,0,0,0,0));
    tv.push_back(v(1,0,32'h40,0,32'hEEEE0000,0,0,0,0, 0,0,1,0,32'h40,0,1,0));
    tv.push_back(v(1,0,32'h40,0,32'hEEEE0001,1,0,0,0, 0,0,1,0,32'h44,0,1,0));

    nRST = 1'b0;
    drive(v(1,0,32'h0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    repeat (2) @(negedge CLK);
    #1;
    check(v(1,0,32'h0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0), "reset_state");
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while parked in LOAD2: outputs clear at once and the frame stays I.
    #2;
    nRST = 1'b0;
    #1;
    check(v(1,0,32'h40,0,0,1,0,0,0, 0,0,0,0,0,0,0,0), "reset_mid_load2");
    @(negedge CLK);
    nRST = 1'b1;
    apply(v(1,0,32'h40,0,0,1,0,0,0, 0,0,0,0,0,0,0,0), "post_reset_miss");
    apply(v(1,0,32'h40,0,0,1,0,0,0, 0,0,1,0,32'h40,0,1,0), "post_reset_fill");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
